// File: rtl/heap_arb_pkg.sv
// Shared heap definitions: request op encodings, address sentinels and
// arbiter FSM states.
package heap_arb_pkg;

  typedef enum logic [1:0] {
    OP_ALLOC = 2'd0,
    OP_FREE  = 2'd1,
    OP_READ  = 2'd2,
    OP_WRITE = 2'd3
  } heap_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } arb_state_e;

  // Sentinels wide enough for any heap word; users slice to DATA_SZ.
  localparam logic [63:0] HEAP_NIL   = 64'd0;
  localparam logic [63:0] HEAP_UNDEF = {64{1'b1}};

endpackage

// File: rtl/heap_arb_rr_arb2.sv
// Two-way round-robin grant. The pointer remembers the last granted
// requester and only moves when the caller reports a completed transfer.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic last_q;

  // Grant the requester not served last when both ask, else the lone one
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
  end

  // Pointer reset to "requester 1 last" so requester 0 wins first
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  last_q <= 1'b1;
    else if (adv)  last_q <= gnt[1];
  end

endmodule

// File: rtl/heap_arb.sv
// Two-requester front end for the heap allocator: round-robin grant,
// ALLOC/FREE pairing, one-cycle response, live-cell tracking and a
// sticky halt on misuse or allocator error.
module heap_arb
  import heap_arb_pkg::*;
#(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [1:0]           i_req_valid,
  output logic [1:0]           o_req_ready,
  input  logic [3:0]           i_req_op,
  input  logic [2*DATA_SZ-1:0] i_req_addr,
  input  logic [2*DATA_SZ-1:0] i_req_data,
  output logic [1:0]           o_rsp_valid,
  output logic [DATA_SZ-1:0]   o_rsp_data,
  output logic                 o_h_alloc,
  output logic [DATA_SZ-1:0]   o_h_data,
  output logic                 o_h_free,
  output logic [DATA_SZ-1:0]   o_h_addr,
  output logic                 o_h_wr,
  output logic [DATA_SZ-1:0]   o_h_waddr,
  output logic [DATA_SZ-1:0]   o_h_wdata,
  output logic                 o_h_rd,
  output logic [DATA_SZ-1:0]   o_h_raddr,
  input  logic [DATA_SZ-1:0]   i_h_addr,
  input  logic [DATA_SZ-1:0]   i_h_rdata,
  input  logic                 i_h_err,
  output logic [ADDR_SZ:0]     o_live,
  output logic                 o_halt
);

  localparam logic [ADDR_SZ:0]   LIVE_FULL = {1'b1, {ADDR_SZ{1'b0}}};
  localparam logic [DATA_SZ-1:0] D_NIL     = HEAP_NIL[DATA_SZ-1:0];

  arb_state_e         state_q, state_d;
  logic [ADDR_SZ:0]   live_q;
  logic [1:0]         rsp_own_q;
  heap_op_e           rsp_op_q;

  heap_op_e           op0, op1, g_op;
  logic [DATA_SZ-1:0] addr0, addr1, data0, data1, g_addr, g_data;
  logic [1:0]         gnt, ready;
  logic               paired, illegal, rr_adv, live_inc, live_dec;

  assign op0   = heap_op_e'(i_req_op[1:0]);
  assign op1   = heap_op_e'(i_req_op[3:2]);
  assign addr0 = i_req_addr[DATA_SZ-1:0];
  assign addr1 = i_req_addr[2*DATA_SZ-1:DATA_SZ];
  assign data0 = i_req_data[DATA_SZ-1:0];
  assign data1 = i_req_data[2*DATA_SZ-1:DATA_SZ];

  rr_arb2 u_rr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .req     (i_req_valid),
    .adv     (rr_adv),
    .gnt     (gnt)
  );

  // Classify the cycle: pairing, granted request, and heap-limit violations
  always_comb begin
    paired  = (&i_req_valid) &&
              ((op0 == OP_ALLOC && op1 == OP_FREE) || (op0 == OP_FREE && op1 == OP_ALLOC));
    g_op    = gnt[1] ? op1   : op0;
    g_addr  = gnt[1] ? addr1 : addr0;
    g_data  = gnt[1] ? data1 : data0;
    illegal = 1'b0;
    if (paired)
      illegal = (live_q == LIVE_FULL);
    else if (|gnt)
      illegal = (g_op == OP_FREE  && live_q == '0) ||
                (g_op == OP_ALLOC && live_q == LIVE_FULL);
  end

  // Next state, ready and heap strobes; nothing issues in reset or HALT
  always_comb begin
    state_d   = state_q;
    ready     = 2'b00;
    rr_adv    = 1'b0;
    live_inc  = 1'b0;
    live_dec  = 1'b0;
    o_h_alloc = 1'b0;
    o_h_data  = D_NIL;
    o_h_free  = 1'b0;
    o_h_addr  = D_NIL;
    o_h_wr    = 1'b0;
    o_h_waddr = D_NIL;
    o_h_wdata = D_NIL;
    o_h_rd    = 1'b0;
    o_h_raddr = D_NIL;
    if (state_q == ST_RUN && (i_h_err || illegal)) state_d = ST_HALT;
    if (i_rst_n && state_q == ST_RUN && !illegal) begin
      if (paired) begin
        // Alloc and free cancel out: both served, pointer and count hold
        ready     = 2'b11;
        o_h_alloc = 1'b1;
        o_h_free  = 1'b1;
        o_h_data  = (op0 == OP_ALLOC) ? data0 : data1;
        o_h_addr  = (op0 == OP_FREE)  ? addr0 : addr1;
      end else if (|gnt) begin
        ready  = gnt;
        rr_adv = 1'b1;
        case (g_op)
          OP_ALLOC: begin o_h_alloc = 1'b1; o_h_data  = g_data; live_inc = 1'b1; end
          OP_FREE:  begin o_h_free  = 1'b1; o_h_addr  = g_addr; live_dec = 1'b1; end
          OP_READ:  begin o_h_rd    = 1'b1; o_h_raddr = g_addr; end
          default:  begin o_h_wr    = 1'b1; o_h_waddr = g_addr; o_h_wdata = g_data; end
        endcase
      end
    end
  end

  assign o_req_ready = ready;

  // State, response owner/op and live count; reset drops any owed response
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_RUN;
      live_q    <= '0;
      rsp_own_q <= 2'b00;
      rsp_op_q  <= OP_ALLOC;
    end else begin
      state_q   <= state_d;
      rsp_own_q <= ready;
      rsp_op_q  <= paired ? OP_ALLOC : g_op;
      if (live_inc)      live_q <= live_q + 1'b1;
      else if (live_dec) live_q <= live_q - 1'b1;
    end
  end

  // Heap results arrive the cycle after the strobe; steer them by the saved op
  always_comb begin
    o_rsp_data = D_NIL;
    if (|rsp_own_q) begin
      case (rsp_op_q)
        OP_ALLOC: o_rsp_data = i_h_addr;
        OP_READ:  o_rsp_data = i_h_rdata;
        default:  o_rsp_data = D_NIL;
      endcase
    end
  end

  assign o_rsp_valid = rsp_own_q;
  assign o_live      = live_q;
  assign o_halt      = (state_q == ST_HALT);

endmodule
